// File: rtl/oled_pkg.sv
// Shared constants and decoder state type for the OLED serial-link receiver.
package oled_pkg;

    localparam logic [7:0] CMD_SETX     = 8'h15;
    localparam logic [7:0] CMD_SETY     = 8'h75;
    localparam logic [7:0] CMD_SETPIXEL = 8'h5C;
    localparam logic [7:0] CMD_NORMAL   = 8'hA6;
    localparam logic [7:0] CMD_INVERT   = 8'hA7;

    localparam logic [15:0] COLOUR_BLUE  = 16'h063C;
    localparam logic [15:0] COLOUR_WHITE = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        X0,
        X1,
        Y0,
        Y1,
        PIX_HI,
        PIX_LO,
        SKIP
    } dec_state_t;

endpackage

// File: rtl/oled_sdi_deserialiser.sv
// Oversamples SCLK with HCLK and assembles MSB-first bytes framed by nCS.
module oled_sdi_deserialiser (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       nCS,
    input  logic       DnC,
    input  logic       SDIN,
    input  logic       SCLK,
    output logic [7:0] rx_byte,
    output logic       byte_dnc,
    output logic       byte_valid,
    output logic       framing_err
);

    logic       sclk_q, sclk_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       byte_dnc_q, byte_dnc_d;
    logic       byte_valid_q, byte_valid_d;
    logic       framing_err_q, framing_err_d;
    logic       bit_take;

    // A rising SCLK is seen as high now but low last cycle; one high cycle suffices.
    assign bit_take = !nCS && SCLK && !sclk_q;

    always_comb begin
        sclk_d        = SCLK;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        rx_byte_d     = rx_byte_q;
        byte_dnc_d    = byte_dnc_q;
        byte_valid_d  = 1'b0;
        framing_err_d = 1'b0;
        if (nCS) begin
            bit_cnt_d     = 3'd0;
            framing_err_d = (bit_cnt_q != 3'd0);
        end else if (bit_take) begin
            shift_d = {shift_q[5:0], SDIN};
            if (bit_cnt_q == 3'd7) begin
                rx_byte_d    = {shift_q, SDIN};
                byte_dnc_d   = DnC;
                byte_valid_d = 1'b1;
                bit_cnt_d    = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sclk_q        <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            rx_byte_q     <= '0;
            byte_dnc_q    <= 1'b0;
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            sclk_q        <= sclk_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_byte_q     <= rx_byte_d;
            byte_dnc_q    <= byte_dnc_d;
            byte_valid_q  <= byte_valid_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign byte_dnc    = byte_dnc_q;
    assign byte_valid  = byte_valid_q;
    assign framing_err = framing_err_q;

endmodule

// File: rtl/oled_sdi_receiver.sv
// Display-side OLED link receiver: decodes window/pixel/invert commands and
// emits one pixel-write strobe per 16-bit colour.
module oled_sdi_receiver
    import oled_pkg::*;
#(
    parameter int COLS   = 128,
    parameter int ROWS   = 128,
    parameter int ADDR_W = 7
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              nCS,
    input  logic              DnC,
    input  logic              SDIN,
    input  logic              SCLK,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_x,
    output logic [ADDR_W-1:0] pix_y,
    output logic [15:0]       pix_colour,
    output logic              invert,
    output logic [15:0]       pixel_count,
    output logic              framing_err,
    output logic              cmd_err
);

    localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    logic [7:0] rx_byte;
    logic       rx_dnc;
    logic       rx_valid;

    dec_state_t        state_q, state_d;
    logic [ADDR_W-1:0] x_start_q, x_start_d, x_end_q, x_end_d;
    logic [ADDR_W-1:0] y_start_q, y_start_d, y_end_q, y_end_d;
    logic [ADDR_W-1:0] x_ptr_q, x_ptr_d, y_ptr_q, y_ptr_d;
    logic [ADDR_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [7:0]        hi_q, hi_d;
    logic              pix_we_q, pix_we_d;
    logic [15:0]       pix_colour_q, pix_colour_d;
    logic              invert_q, invert_d;
    logic [15:0]       pixel_count_q, pixel_count_d;
    logic              cmd_err_q, cmd_err_d;

    oled_sdi_deserialiser u_deser (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .nCS         (nCS),
        .DnC         (DnC),
        .SDIN        (SDIN),
        .SCLK        (SCLK),
        .rx_byte     (rx_byte),
        .byte_dnc    (rx_dnc),
        .byte_valid  (rx_valid),
        .framing_err (framing_err)
    );

    always_comb begin
        state_d       = state_q;
        x_start_d     = x_start_q;
        x_end_d       = x_end_q;
        y_start_d     = y_start_q;
        y_end_d       = y_end_q;
        x_ptr_d       = x_ptr_q;
        y_ptr_d       = y_ptr_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        hi_d          = hi_q;
        pix_we_d      = 1'b0;
        pix_colour_d  = pix_colour_q;
        invert_d      = invert_q;
        pixel_count_d = pixel_count_q;
        cmd_err_d     = 1'b0;
        if (rx_valid && !rx_dnc) begin
            // Any command restarts decoding, discarding a half-received pixel.
            case (rx_byte)
                CMD_SETX: state_d = X0;
                CMD_SETY: state_d = Y0;
                CMD_SETPIXEL: begin
                    state_d = PIX_HI;
                    x_ptr_d = x_start_q;
                    y_ptr_d = y_start_q;
                end
                CMD_NORMAL: begin
                    invert_d = 1'b0;
                    state_d  = IDLE;
                end
                CMD_INVERT: begin
                    invert_d = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    cmd_err_d = 1'b1;
                    state_d   = SKIP;
                end
            endcase
        end else if (rx_valid) begin
            case (state_q)
                IDLE: cmd_err_d = 1'b1;
                X0: begin
                    x_start_d = rx_byte[ADDR_W-1:0];
                    state_d   = X1;
                end
                X1: begin
                    x_end_d = rx_byte[ADDR_W-1:0];
                    state_d = IDLE;
                end
                Y0: begin
                    y_start_d = rx_byte[ADDR_W-1:0];
                    state_d   = Y1;
                end
                Y1: begin
                    y_end_d = rx_byte[ADDR_W-1:0];
                    state_d = IDLE;
                end
                PIX_HI: begin
                    hi_d    = rx_byte;
                    state_d = PIX_LO;
                end
                PIX_LO: begin
                    pix_we_d      = 1'b1;
                    pix_x_d       = x_ptr_q;
                    pix_y_d       = y_ptr_q;
                    pix_colour_d  = {hi_q, rx_byte};
                    pixel_count_d = pixel_count_q + 16'd1;
                    state_d       = PIX_HI;
                    // Raster order inside the window; a start above end wraps through 0.
                    if (x_ptr_q == x_end_q) begin
                        x_ptr_d = x_start_q;
                        if (y_ptr_q == y_end_q) begin
                            y_ptr_d = y_start_q;
                        end else begin
                            y_ptr_d = (y_ptr_q == Y_MAX) ? '0 : y_ptr_q + ONE;
                        end
                    end else begin
                        x_ptr_d = (x_ptr_q == X_MAX) ? '0 : x_ptr_q + ONE;
                    end
                end
                SKIP: state_d = SKIP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= IDLE;
            x_start_q     <= '0;
            x_end_q       <= X_MAX;
            y_start_q     <= '0;
            y_end_q       <= Y_MAX;
            x_ptr_q       <= '0;
            y_ptr_q       <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            hi_q          <= '0;
            pix_we_q      <= 1'b0;
            pix_colour_q  <= '0;
            invert_q      <= 1'b0;
            pixel_count_q <= '0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_start_q     <= x_start_d;
            x_end_q       <= x_end_d;
            y_start_q     <= y_start_d;
            y_end_q       <= y_end_d;
            x_ptr_q       <= x_ptr_d;
            y_ptr_q       <= y_ptr_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            hi_q          <= hi_d;
            pix_we_q      <= pix_we_d;
            pix_colour_q  <= pix_colour_d;
            invert_q      <= invert_d;
            pixel_count_q <= pixel_count_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign pix_we      = pix_we_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_colour  = pix_colour_q;
    assign invert      = invert_q;
    assign pixel_count = pixel_count_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_oled_sdi_receiver.sv
// Self-checking bench: bit-level serial driver, window/raster reference model
// built from enumerated column/row lists, and per-feature test tasks.
module tb_oled_sdi_receiver;

    localparam int COLS = 128;
    localparam int ROWS = 128;

    typedef struct packed {
        logic [6:0]  x;
        logic [6:0]  y;
        logic [15:0] c;
    } pix_t;

    logic        HCLK = 1'b0;
    logic        HRESETn, nCS, DnC, SDIN, SCLK;
    logic        pix_we, invert, framing_err, cmd_err;
    logic [6:0]  pix_x, pix_y;
    logic [15:0] pix_colour, pixel_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_bit_cyc = 0;

    pix_t obs_q[$];
    int   obs_cmd_err = 0;
    int   obs_ferr = 0;
    int   obs_we_cyc = 0;
    int   obs_inv_cyc = 0;
    logic inv_prev = 1'b0;

    // Reference model state
    int         m_mode;
    int         m_x0, m_x1, m_y0, m_y1, m_k;
    int         m_cols[$];
    int         m_rows[$];
    logic [7:0] m_hi;
    logic       m_inv;
    int         m_count;
    int         m_cmd_err = 0;
    pix_t       exp_q[$];

    oled_sdi_receiver dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .nCS         (nCS),
        .DnC         (DnC),
        .SDIN        (SDIN),
        .SCLK        (SCLK),
        .pix_we      (pix_we),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_colour  (pix_colour),
        .invert      (invert),
        .pixel_count (pixel_count),
        .framing_err (framing_err),
        .cmd_err     (cmd_err)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (pix_we) begin
                obs_q.push_back({pix_x, pix_y, pix_colour});
                obs_we_cyc <= cyc;
            end
            if (cmd_err) obs_cmd_err <= obs_cmd_err + 1;
            if (framing_err) obs_ferr <= obs_ferr + 1;
        end
        if (invert !== inv_prev) obs_inv_cyc <= cyc;
        inv_prev <= invert;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_mode = 0;
        m_x0 = 0; m_x1 = COLS - 1;
        m_y0 = 0; m_y1 = ROWS - 1;
        m_k = 0;
        m_hi = 8'h00;
        m_inv = 1'b0;
        m_count = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic dnc);
        pix_t e;
        int   v;
        if (!dnc) begin
            case (b)
                8'h15: m_mode = 1;
                8'h75: m_mode = 3;
                8'h5C: begin
                    m_mode = 5;
                    m_k = 0;
                    m_cols.delete();
                    m_rows.delete();
                    v = m_x0;
                    m_cols.push_back(v);
                    while (v != m_x1) begin v = (v + 1) % COLS; m_cols.push_back(v); end
                    v = m_y0;
                    m_rows.push_back(v);
                    while (v != m_y1) begin v = (v + 1) % ROWS; m_rows.push_back(v); end
                end
                8'hA6: begin m_inv = 1'b0; m_mode = 0; end
                8'hA7: begin m_inv = 1'b1; m_mode = 0; end
                default: begin m_cmd_err++; m_mode = 7; end
            endcase
        end else begin
            case (m_mode)
                0: m_cmd_err++;
                1: begin m_x0 = int'(b[6:0]); m_mode = 2; end
                2: begin m_x1 = int'(b[6:0]); m_mode = 0; end
                3: begin m_y0 = int'(b[6:0]); m_mode = 4; end
                4: begin m_y1 = int'(b[6:0]); m_mode = 0; end
                5: begin m_hi = b; m_mode = 6; end
                6: begin
                    e.x = 7'(m_cols[m_k % m_cols.size()]);
                    e.y = 7'(m_rows[(m_k / m_cols.size()) % m_rows.size()]);
                    e.c = {m_hi, b};
                    exp_q.push_back(e);
                    m_k++;
                    m_count = (m_count + 1) % 65536;
                    m_mode = 5;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    task automatic drive_bits(input logic [7:0] b, input logic dnc, input int nbits);
        nCS = 1'b0;
        DnC = dnc;
        SCLK = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            SDIN = b[i];
            tick($urandom_range(1, 2));
            SCLK = 1'b1;
            if (i == 0) last_bit_cyc = cyc;
            tick($urandom_range(1, 2));
            SCLK = 1'b0;
        end
        tick(1);
        nCS = 1'b1;
        tick($urandom_range(1, 2));
    endtask

    task automatic send_cmd(input logic [7:0] b);
        drive_bits(b, 1'b0, 8);
        model_byte(b, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] b);
        drive_bits(b, 1'b1, 8);
        model_byte(b, 1'b1);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; nCS = 1'b1; DnC = 1'b0; SDIN = 1'b0; SCLK = 1'b0;
        model_reset();
        tick(3);
        HRESETn = 1'b1;
        tick(3);
        vectors++;
        if ({pix_we, pix_x, pix_y, pix_colour, invert, pixel_count, framing_err, cmd_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got we=%0b x=%0h y=%0h c=%0h inv=%0b cnt=%0h fe=%0b ce=%0b expected all 0",
                     pix_we, pix_x, pix_y, pix_colour, invert, pixel_count, framing_err, cmd_err);
        end
    endtask

    task automatic test_window_fill();
        int base = obs_q.size();
        send_cmd(8'h15); send_data(8'h0E); send_data(8'h15);
        send_cmd(8'h75); send_data(8'h1F); send_data(8'h2B);
        send_cmd(8'h5C);
        for (int i = 0; i < 104; i++) begin
            send_data(8'($urandom)); send_data(8'($urandom));
        end
        tick(4);
        vectors++;
        if (obs_q.size() - base != 104) begin
            miscompares++;
            $display("[TB] FAIL fill_count: got %0d strobes expected 104", obs_q.size() - base);
        end
        for (int i = base; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL fill_pixel[%0d]: got %h expected %h", i - base, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() >= base + 104) begin
            vectors += 3;
            if (obs_q[base].x !== 7'h0E || obs_q[base].y !== 7'h1F) begin
                miscompares++;
                $display("[TB] FAIL fill_first: got (%0h,%0h) expected (e,1f)", obs_q[base].x, obs_q[base].y);
            end
            if (obs_q[base+8].x !== 7'h0E || obs_q[base+8].y !== 7'h20) begin
                miscompares++;
                $display("[TB] FAIL fill_ninth: got (%0h,%0h) expected (e,20)", obs_q[base+8].x, obs_q[base+8].y);
            end
            if (obs_q[base+103].x !== 7'h15 || obs_q[base+103].y !== 7'h2B) begin
                miscompares++;
                $display("[TB] FAIL fill_last: got (%0h,%0h) expected (15,2b)", obs_q[base+103].x, obs_q[base+103].y);
            end
        end
        vectors++;
        if (pixel_count !== 16'd104) begin
            miscompares++;
            $display("[TB] FAIL fill_pixel_count: got %0d expected 104", pixel_count);
        end
    endtask

    task automatic test_window_wrap();
        int base = obs_q.size();
        for (int i = 0; i < 2; i++) begin
            send_data(8'($urandom)); send_data(8'($urandom));
        end
        tick(4);
        vectors++;
        if (obs_q.size() - base != 2) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got %0d expected 2", obs_q.size() - base);
        end else begin
            vectors += 2;
            if (obs_q[base].x !== 7'h0E || obs_q[base].y !== 7'h1F || obs_q[base] !== exp_q[base]) begin
                miscompares++;
                $display("[TB] FAIL wrap_first: got %h expected %h at (e,1f)", obs_q[base], exp_q[base]);
            end
            if (obs_q[base+1].x !== 7'h0F || obs_q[base+1].y !== 7'h1F || obs_q[base+1] !== exp_q[base+1]) begin
                miscompares++;
                $display("[TB] FAIL wrap_second: got %h expected %h at (f,1f)", obs_q[base+1], exp_q[base+1]);
            end
        end
        vectors++;
        if (pixel_count !== 16'd106) begin
            miscompares++;
            $display("[TB] FAIL wrap_pixel_count: got %0d expected 106", pixel_count);
        end
    endtask

    task automatic test_colour();
        send_data(8'h06); send_data(8'h3C);
        tick(4);
        vectors += 2;
        if (pix_colour !== oled_pkg::COLOUR_BLUE) begin
            miscompares++;
            $display("[TB] FAIL colour_blue: got %h expected 063c", pix_colour);
        end
        if (obs_we_cyc - last_bit_cyc != 2) begin
            miscompares++;
            $display("[TB] FAIL pix_we_latency: got %0d cycles expected 2", obs_we_cyc - last_bit_cyc);
        end
        send_data(8'hFF); send_data(8'hFF);
        tick(4);
        vectors += 2;
        if (pix_colour !== oled_pkg::COLOUR_WHITE) begin
            miscompares++;
            $display("[TB] FAIL colour_white: got %h expected ffff", pix_colour);
        end
        if (obs_q.size() != exp_q.size() || obs_q[obs_q.size()-1] !== exp_q[exp_q.size()-1]) begin
            miscompares++;
            $display("[TB] FAIL colour_position: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_invert();
        int base = obs_q.size();
        int ce = obs_cmd_err;
        send_cmd(8'hA7);
        tick(4);
        vectors += 2;
        if (invert !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL invert_set: got %0b expected 1", invert);
        end
        if (obs_inv_cyc - last_bit_cyc != 2) begin
            miscompares++;
            $display("[TB] FAIL invert_latency: got %0d cycles expected 2", obs_inv_cyc - last_bit_cyc);
        end
        send_cmd(8'hA6);
        tick(4);
        vectors += 3;
        if (invert !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL invert_clear: got %0b expected 0", invert);
        end
        if (obs_q.size() != base) begin
            miscompares++;
            $display("[TB] FAIL invert_no_pix: got %0d strobes expected 0", obs_q.size() - base);
        end
        if (obs_cmd_err != ce) begin
            miscompares++;
            $display("[TB] FAIL invert_no_cmd_err: got %0d pulses expected 0", obs_cmd_err - ce);
        end
    endtask

    task automatic test_framing();
        int fe = obs_ferr;
        int ce = obs_cmd_err;
        int base = obs_q.size();
        drive_bits(8'hE0, 1'b0, 3);
        tick(2);
        vectors++;
        if (obs_ferr - fe != 1) begin
            miscompares++;
            $display("[TB] FAIL framing_pulse: got %0d pulses expected 1", obs_ferr - fe);
        end
        send_cmd(8'h15); send_data(8'h03); send_data(8'h05);
        send_cmd(8'h75); send_data(8'h10); send_data(8'h10);
        send_cmd(8'h5C);
        for (int i = 0; i < 4; i++) begin
            send_data(8'($urandom)); send_data(8'($urandom));
        end
        tick(4);
        vectors += 2;
        if (obs_ferr - fe != 1) begin
            miscompares++;
            $display("[TB] FAIL framing_once: got %0d pulses expected 1", obs_ferr - fe);
        end
        if (obs_cmd_err != ce) begin
            miscompares++;
            $display("[TB] FAIL framing_cmd_err: got %0d pulses expected 0", obs_cmd_err - ce);
        end
        vectors++;
        if (obs_q.size() - base != 4) begin
            miscompares++;
            $display("[TB] FAIL framing_strobes: got %0d expected 4", obs_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (obs_q[base+i].x !== 7'((i == 3) ? 3 : 3 + i) || obs_q[base+i].y !== 7'h10
                    || obs_q[base+i] !== exp_q[base+i]) begin
                    miscompares++;
                    $display("[TB] FAIL framing_pixel[%0d]: got %h expected %h", i, obs_q[base+i], exp_q[base+i]);
                end
            end
        end
    endtask

    task automatic test_cmd_err_and_reset();
        int ce;
        int base;
        send_cmd(8'hA6);
        tick(2);
        ce = obs_cmd_err;
        send_data(8'hAA);
        tick(4);
        vectors++;
        if (obs_cmd_err - ce != 1) begin
            miscompares++;
            $display("[TB] FAIL cmd_err_idle_data: got %0d pulses expected 1", obs_cmd_err - ce);
        end
        base = obs_q.size();
        send_cmd(8'hB3); send_data(8'h11); send_data(8'h22);
        tick(4);
        vectors += 2;
        if (obs_cmd_err - ce != 2) begin
            miscompares++;
            $display("[TB] FAIL cmd_err_unknown: got %0d pulses expected 2", obs_cmd_err - ce);
        end
        if (obs_q.size() != base) begin
            miscompares++;
            $display("[TB] FAIL cmd_err_skip: got %0d strobes expected 0", obs_q.size() - base);
        end
        send_cmd(8'h5C); send_data(8'h12);
        HRESETn = 1'b0;
        #2;
        vectors++;
        if ({pix_we, pix_x, pix_y, pix_colour, invert, pixel_count, framing_err, cmd_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_outputs: got x=%0h y=%0h c=%0h cnt=%0h expected all 0",
                     pix_x, pix_y, pix_colour, pixel_count);
        end
        model_reset();
        tick(2);
        HRESETn = 1'b1;
        tick(2);
        base = obs_q.size();
        send_cmd(8'h5C);
        for (int i = 0; i < 130; i++) begin
            send_data(8'($urandom)); send_data(8'($urandom));
        end
        tick(4);
        vectors++;
        if (obs_q.size() - base != 130) begin
            miscompares++;
            $display("[TB] FAIL reset_window_strobes: got %0d expected 130", obs_q.size() - base);
        end else begin
            vectors += 3;
            if (obs_q[base].x !== 7'd0 || obs_q[base].y !== 7'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_window_origin: got (%0d,%0d) expected (0,0)", obs_q[base].x, obs_q[base].y);
            end
            if (obs_q[base+127].x !== 7'd127 || obs_q[base+127].y !== 7'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_window_xend: got (%0d,%0d) expected (127,0)", obs_q[base+127].x, obs_q[base+127].y);
            end
            if (obs_q[base+128].x !== 7'd0 || obs_q[base+128].y !== 7'd1) begin
                miscompares++;
                $display("[TB] FAIL reset_window_nextrow: got (%0d,%0d) expected (0,1)", obs_q[base+128].x, obs_q[base+128].y);
            end
            for (int i = base; i < obs_q.size() && i < exp_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("[TB] FAIL reset_window_pixel[%0d]: got %h expected %h", i - base, obs_q[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (pixel_count !== 16'd130) begin
            miscompares++;
            $display("[TB] FAIL reset_pixel_count: got %0d expected 130", pixel_count);
        end
    endtask

    task automatic test_random_windows();
        int base;
        int n;
        for (int it = 0; it < 5; it++) begin
            base = obs_q.size();
            send_cmd(8'h15); send_data(8'($urandom)); send_data(8'($urandom));
            send_cmd(8'h75); send_data(8'($urandom)); send_data(8'($urandom));
            if ($urandom_range(0, 1) == 1) send_cmd(($urandom_range(0, 1) == 1) ? 8'hA7 : 8'hA6);
            send_cmd(8'h5C);
            n = $urandom_range(10, 40);
            for (int i = 0; i < n; i++) begin
                send_data(8'($urandom)); send_data(8'($urandom));
            end
            tick(4);
            vectors += 3;
            if (obs_q.size() - base != n) begin
                miscompares++;
                $display("[TB] FAIL rand_strobes[%0d]: got %0d expected %0d", it, obs_q.size() - base, n);
            end
            if (invert !== m_inv) begin
                miscompares++;
                $display("[TB] FAIL rand_invert[%0d]: got %0b expected %0b", it, invert, m_inv);
            end
            if (pixel_count !== 16'(m_count)) begin
                miscompares++;
                $display("[TB] FAIL rand_pixel_count[%0d]: got %0d expected %0d", it, pixel_count, m_count);
            end
            for (int i = base; i < obs_q.size() && i < exp_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("[TB] FAIL rand_pixel[%0d.%0d]: got %h expected %h", it, i - base, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_window_fill();
        test_window_wrap();
        test_colour();
        test_invert();
        test_framing();
        test_cmd_err_and_reset();
        test_random_windows();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
